// File: rtl/sccb_config.sv
// sccb_config: SCCB (I2C-like) write master that programs the OV7670 sensor
// from a small internal ROM once a start request arrives.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   iniciar    start request (single-cycle pulse), honoured only in IDLE/DONE
//   SDIOC      SCCB clock, idles high
//   SDIOD      SCCB data, always driven, idles high
//   ocupado    high while a configuration run is in progress
//   pronto     high once every ROM entry has been written; held until the next
//              iniciar or reset
//   db_indice  index of the ROM entry being written
//   db_estado  FSM state code
//
// Every SCCB bit is built from four quarter phases of QUARTER clocks each. The
// pin levels are decoded from (state, phase) and registered, so the waveform
// lags the FSM by one clock uniformly and all edges keep their relative order.
module sccb_config #(
    parameter int          QUARTER    = 125,
    parameter int          N_REGS     = 6,
    parameter int          RESET_WAIT = 50000,
    parameter logic [7:0]  DEV_ID     = 8'h42
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic       SDIOC,
    output logic       SDIOD,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_indice,
    output logic [3:0] db_estado
);

    localparam int TW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int WW = (RESET_WAIT > 1) ? $clog2(RESET_WAIT + 1) : 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_BYTE     = 4'd2,
        ST_XBIT     = 4'd3,
        ST_STOP     = 4'd4,
        ST_GAP      = 4'd5,
        ST_WAIT_RST = 4'd6,
        ST_DONE     = 4'd7
    } state_t;

    // Register/value pairs written in index order.
    function automatic logic [15:0] rom_entry(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'h1280;   // COM7: soft reset
            4'd1:    val = 16'h1204;   // COM7: RGB output
            4'd2:    val = 16'h40D0;   // COM15: RGB565, full range
            4'd3:    val = 16'h1101;   // CLKRC: prescaler
            4'd4:    val = 16'h0C00;   // COM3
            4'd5:    val = 16'h3E00;   // COM14
            default: val = 16'h0000;
        endcase
        return val;
    endfunction

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [1:0]      phase_r;
    logic [WW-1:0]   wait_cnt_r;
    logic [3:0]      indice_r;
    logic [1:0]      fase_r;
    logic [2:0]      bit_r;
    logic            sdioc_r;
    logic            sdiod_r;
    logic            ocupado_r;
    logic            pronto_r;

    logic [15:0]     rom_s;
    logic [7:0]      byte_s;
    logic            quarter_end_s;
    logic            phase_end_s;
    logic            timed_s;
    logic            pin_c_s;
    logic            pin_d_s;

    // Current ROM entry, the byte selected by fase, and quarter/bit timing strobes.
    always_comb begin
        rom_s = rom_entry(indice_r);
        case (fase_r)
            2'd0:    byte_s = DEV_ID;
            2'd1:    byte_s = rom_s[15:8];
            2'd2:    byte_s = rom_s[7:0];
            default: byte_s = DEV_ID;
        endcase
        quarter_end_s = (timer_r == TW'(QUARTER - 1));
        phase_end_s   = quarter_end_s && (phase_r == 2'd3);
        timed_s       = (state_r == ST_START) || (state_r == ST_BYTE) ||
                        (state_r == ST_XBIT)  || (state_r == ST_STOP) ||
                        (state_r == ST_GAP);
    end

    // Pin levels for the current state and quarter phase.
    always_comb begin
        pin_c_s = 1'b1;
        pin_d_s = 1'b1;
        case (state_r)
            ST_START: begin
                // SDIOD falls while SDIOC is high: START condition
                case (phase_r)
                    2'd0:    begin pin_c_s = 1'b1; pin_d_s = 1'b1; end
                    2'd1:    begin pin_c_s = 1'b1; pin_d_s = 1'b0; end
                    default: begin pin_c_s = 1'b0; pin_d_s = 1'b0; end
                endcase
            end
            ST_BYTE, ST_XBIT: begin
                // data set up in q0 with SDIOC low, clock high through q1..q2
                if (state_r == ST_BYTE) begin
                    pin_d_s = byte_s[bit_r];
                end else begin
                    pin_d_s = 1'b1;
                end
                if ((phase_r == 2'd1) || (phase_r == 2'd2)) begin
                    pin_c_s = 1'b1;
                end else begin
                    pin_c_s = 1'b0;
                end
            end
            ST_STOP: begin
                // SDIOD rises while SDIOC is high: STOP condition
                case (phase_r)
                    2'd0:    begin pin_c_s = 1'b0; pin_d_s = 1'b0; end
                    2'd1:    begin pin_c_s = 1'b1; pin_d_s = 1'b0; end
                    default: begin pin_c_s = 1'b1; pin_d_s = 1'b1; end
                endcase
            end
            default: begin
                pin_c_s = 1'b1;
                pin_d_s = 1'b1;
            end
        endcase
    end

    // Main FSM with quarter timer, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            timer_r    <= '0;
            phase_r    <= 2'd0;
            wait_cnt_r <= '0;
            indice_r   <= 4'd0;
            fase_r     <= 2'd0;
            bit_r      <= 3'd7;
            sdioc_r    <= 1'b1;
            sdiod_r    <= 1'b1;
            ocupado_r  <= 1'b0;
            pronto_r   <= 1'b0;
        end else begin
            sdioc_r <= pin_c_s;
            sdiod_r <= pin_d_s;

            // Timer and phase run only in the bit-timed states; elsewhere
            // they sit at zero so every timed state starts on a clean q0.
            if (timed_s) begin
                if (quarter_end_s) begin
                    timer_r <= '0;
                    phase_r <= phase_r + 2'd1;
                end else begin
                    timer_r <= timer_r + TW'(1);
                end
            end else begin
                timer_r <= '0;
                phase_r <= 2'd0;
            end

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (iniciar) begin
                        state_r   <= ST_START;
                        indice_r  <= 4'd0;
                        fase_r    <= 2'd0;
                        bit_r     <= 3'd7;
                        ocupado_r <= 1'b1;
                        pronto_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (phase_end_s) begin
                        state_r <= ST_BYTE;
                        fase_r  <= 2'd0;
                        bit_r   <= 3'd7;
                    end
                end
                ST_BYTE: begin
                    if (phase_end_s) begin
                        if (bit_r == 3'd0) begin
                            state_r <= ST_XBIT;
                        end else begin
                            bit_r <= bit_r - 3'd1;
                        end
                    end
                end
                ST_XBIT: begin
                    // ninth bit is a don't-care; the sensor's ACK is not sampled
                    if (phase_end_s) begin
                        if (fase_r < 2'd2) begin
                            fase_r  <= fase_r + 2'd1;
                            bit_r   <= 3'd7;
                            state_r <= ST_BYTE;
                        end else begin
                            state_r <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (phase_end_s) begin
                        // the sensor needs time to recover after a COM7 soft reset
                        if (rom_s == 16'h1280) begin
                            state_r    <= ST_WAIT_RST;
                            wait_cnt_r <= '0;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end
                end
                ST_WAIT_RST: begin
                    if (wait_cnt_r == WW'(RESET_WAIT - 1)) begin
                        state_r    <= ST_GAP;
                        wait_cnt_r <= '0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WW'(1);
                    end
                end
                ST_GAP: begin
                    if (phase_end_s) begin
                        if (indice_r == 4'(N_REGS - 1)) begin
                            state_r   <= ST_DONE;
                            ocupado_r <= 1'b0;
                            pronto_r  <= 1'b1;
                        end else begin
                            indice_r <= indice_r + 4'd1;
                            state_r  <= ST_START;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign SDIOC     = sdioc_r;
    assign SDIOD     = sdiod_r;
    assign ocupado   = ocupado_r;
    assign pronto    = pronto_r;
    assign db_indice = indice_r;
    assign db_estado = state_r;

endmodule
